// File: rtl/fp_pkg.sv
// fp_pkg: shared classes, constants and flag layout for the FP multiplier datapath
package fp_pkg;
  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    ZERO   = 2'b01,
    INF    = 2'b10,
    NAN    = 2'b11
  } fp_class_e;
  localparam int FP_BIAS = 127;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam logic [7:0] FP_EXP_MAX = 8'hFF;
  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;
endpackage

// File: rtl/fp_round_rne.sv
// fp_round_rne: round-to-nearest-even of a 24-bit significand, renormalizing on carry
module fp_round_rne (
  input  logic [23:0] i_mant,
  input  logic        i_g,
  input  logic        i_s,
  output logic [22:0] o_frac,
  output logic        o_carry
);
  logic [24:0] w_sum;
  assign w_sum = {1'b0, i_mant} + 25'(i_g & (i_s | i_mant[0]));
  assign o_carry = w_sum[24];
  // the hidden bit is implicit, so only the fraction leaves this block
  assign o_frac = o_carry ? w_sum[23:1] : w_sum[22:0];
endmodule

// File: rtl/fp_mul_round_pack.sv
// fp_mul_round_pack: normalize, round, resolve specials and pack an FP32 product; FP_MUL_FLAGS_EN adds IEEE flags
module fp_mul_round_pack
  import fp_pkg::*;
#(
  parameter int BIAS  = 127,
  parameter int EXP_W = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [8:0]  in_exp_sum,
  input  logic [47:0] in_prod,
  input  logic [1:0]  in_a_class,
  input  logic [1:0]  in_b_class,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result
`ifdef FP_MUL_FLAGS_EN
  ,
  output logic [3:0]  out_flags,
  input  logic        flags_clr,
  output logic [3:0]  flags_sticky
`endif
);
  logic                    w_s2_adv;
  logic                    w_hi;
  logic [23:0]             w_mant;
  logic                    w_g;
  logic                    w_s;
  logic signed [EXP_W-1:0] w_exp;
  logic                    r_s1_valid;
  logic                    r_s1_sign;
  logic signed [EXP_W-1:0] r_s1_exp;
  logic [23:0]             r_s1_mant;
  logic                    r_s1_g;
  logic                    r_s1_s;
  fp_class_e               r_s1_a_class;
  fp_class_e               r_s1_b_class;
  logic [22:0]             w_frac;
  logic                    w_carry;
  logic signed [EXP_W-1:0] w_exp_r;
  logic                    w_nan;
  logic                    w_inf;
  logic                    w_zero;
  logic                    w_invalid;
  logic                    w_ovf;
  logic                    w_unf;
  logic [31:0]             w_result;
  logic                    r_out_valid;
  logic [31:0]             r_out_result;
  assign w_s2_adv  = !r_out_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_adv;
  assign out_valid = r_out_valid;
  assign out_result = r_out_result;
  // normalization: the product of two [1,2) significands lies in [1,4)
  assign w_hi   = in_prod[47];
  assign w_mant = w_hi ? in_prod[47:24] : in_prod[46:23];
  assign w_g    = w_hi ? in_prod[23] : in_prod[22];
  assign w_s    = w_hi ? |in_prod[22:0] : |in_prod[21:0];
  assign w_exp  = EXP_W'({1'b0, in_exp_sum}) - EXP_W'(BIAS) + EXP_W'(w_hi);
  // stage 1: capture the normalized significand, exponent and operand classes
  always_ff @(posedge clk) begin
    if (rstn) r_s1_valid <= 1'b0;
    else if (in_ready) r_s1_valid <= in_valid;
    if (in_valid && in_ready) begin
      r_s1_sign    <= in_sign;
      r_s1_exp     <= w_exp;
      r_s1_mant    <= w_mant;
      r_s1_g       <= w_g;
      r_s1_s       <= w_s;
      r_s1_a_class <= fp_class_e'(in_a_class);
      r_s1_b_class <= fp_class_e'(in_b_class);
    end
  end
  fp_round_rne u_round (
    .i_mant (r_s1_mant),
    .i_g    (r_s1_g),
    .i_s    (r_s1_s),
    .o_frac (w_frac),
    .o_carry(w_carry)
  );
  assign w_exp_r   = r_s1_exp + EXP_W'(w_carry);
  assign w_nan     = r_s1_a_class == NAN || r_s1_b_class == NAN;
  assign w_inf     = r_s1_a_class == INF || r_s1_b_class == INF;
  assign w_zero    = r_s1_a_class == ZERO || r_s1_b_class == ZERO;
  assign w_invalid = w_nan || (w_inf && w_zero);
  assign w_ovf     = w_exp_r >= 255;
  assign w_unf     = w_exp_r <= 0;
  // special cases outrank range checks; overflow saturates to inf, underflow flushes to zero
  always_comb begin
    w_result = w_invalid ? FP_QNAN :
               w_inf     ? {r_s1_sign, FP_EXP_MAX, 23'h0} :
               w_zero    ? {r_s1_sign, 31'h0} :
               w_ovf     ? {r_s1_sign, FP_EXP_MAX, 23'h0} :
               w_unf     ? {r_s1_sign, 31'h0} :
                           {r_s1_sign, w_exp_r[7:0], w_frac};
  end
  // stage 2: register the packed result whenever the output slot frees up
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_out_valid  <= 1'b0;
      r_out_result <= 32'h0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) r_out_result <= w_result;
    end
  end
`ifdef FP_MUL_FLAGS_EN
  logic      w_special;
  fp_flags_t w_flags;
  fp_flags_t r_out_flags;
  fp_flags_t r_sticky;
  assign w_special = w_invalid || w_inf || w_zero;
  // flags follow the same priority as the result selection
  always_comb begin
    w_flags.invalid   = w_invalid;
    w_flags.overflow  = !w_special && w_ovf;
    w_flags.underflow = !w_special && !w_ovf && w_unf && |{r_s1_mant, r_s1_g, r_s1_s};
    w_flags.inexact   = (!w_special && !w_ovf && !w_unf && (r_s1_g || r_s1_s)) ||
                        w_flags.overflow || w_flags.underflow;
  end
  // per-result flags travel with out_result; the sticky copy accumulates accepted results
  always_ff @(posedge clk) begin
    if (rstn) r_out_flags <= '0;
    else if (w_s2_adv && r_s1_valid) r_out_flags <= w_flags;
    if (rstn || flags_clr) r_sticky <= '0;
    else if (r_out_valid && out_ready) r_sticky <= r_sticky | r_out_flags;
  end
  assign out_flags    = r_out_flags;
  assign flags_sticky = r_sticky;
`endif
endmodule

// File: tb/tb_fp_mul_round_pack.sv
// tb_fp_mul_round_pack: directed vector table plus backpressure and mid-flight reset sequences
module tb_fp_mul_round_pack;
  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [8:0]  in_exp_sum;
  logic [47:0] in_prod;
  logic [1:0]  in_a_class;
  logic [1:0]  in_b_class;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  int          passed = 0;
  int          total = 0;
`ifdef FP_MUL_FLAGS_EN
  logic [3:0]  out_flags;
  logic [3:0]  flags_sticky;
  logic        flags_clr = 1'b0;
`endif
  typedef struct packed {
    logic        sign;
    logic [8:0]  exp_sum;
    logic [47:0] prod;
    logic [1:0]  ac;
    logic [1:0]  bc;
    logic [31:0] res;
  } vec_t;
  localparam int NV = 19;
  vec_t        vecs[NV];
  logic [8:0]  bp_e[4];
  logic [31:0] bp_r[4];
  fp_mul_round_pack dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp_sum(in_exp_sum),
    .in_prod   (in_prod),
    .in_a_class(in_a_class),
    .in_b_class(in_b_class),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result)
`ifdef FP_MUL_FLAGS_EN
    ,
    .out_flags   (out_flags),
    .flags_clr   (flags_clr),
    .flags_sticky(flags_sticky)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h want %h", name, act, req);
  endtask
  task automatic drive(input vec_t v);
    in_sign    = v.sign;
    in_exp_sum = v.exp_sum;
    in_prod    = v.prod;
    in_a_class = v.ac;
    in_b_class = v.bc;
  endtask
  task automatic run_one(input string name, input vec_t v);
    drive(v);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check({name, " early"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check({name, " valid"}, 32'(out_valid), 32'd1);
    check(name, out_result, v.res);
  endtask
  initial begin
    int   sent;
    int   got;
    logic acc;
    logic ovs;
    logic orr;
    logic [31:0] res;
    vecs[0]  = '{1'b0, 9'd255, 48'h600000000000, 2'd0, 2'd0, 32'h40400000};
    vecs[1]  = '{1'b0, 9'd254, 48'h400000400000, 2'd0, 2'd0, 32'h3F800000};
    vecs[2]  = '{1'b0, 9'd254, 48'h400000C00000, 2'd0, 2'd0, 32'h3F800002};
    vecs[3]  = '{1'b0, 9'd254, 48'h7FFFFFC00000, 2'd0, 2'd0, 32'h40000000};
    vecs[4]  = '{1'b0, 9'd508, 48'h400000000000, 2'd0, 2'd0, 32'h7F800000};
    vecs[5]  = '{1'b0, 9'd100, 48'h400000000000, 2'd0, 2'd0, 32'h00000000};
    vecs[6]  = '{1'b1, 9'd254, 48'h400000000000, 2'd2, 2'd1, 32'h7FC00000};
    vecs[7]  = '{1'b1, 9'd254, 48'h400000000000, 2'd2, 2'd0, 32'hFF800000};
    vecs[8]  = '{1'b1, 9'd254, 48'h400000000000, 2'd0, 2'd3, 32'h7FC00000};
    vecs[9]  = '{1'b1, 9'd254, 48'h400000000000, 2'd1, 2'd0, 32'h80000000};
    vecs[10] = '{1'b1, 9'd127, 48'h400000000000, 2'd0, 2'd0, 32'h80000000};
    vecs[11] = '{1'b0, 9'd127, 48'h800000000000, 2'd0, 2'd0, 32'h00800000};
    vecs[12] = '{1'b0, 9'd127, 48'h7FFFFFC00000, 2'd0, 2'd0, 32'h00800000};
    vecs[13] = '{1'b0, 9'd381, 48'h400000000000, 2'd0, 2'd0, 32'h7F000000};
    vecs[14] = '{1'b0, 9'd381, 48'h7FFFFFC00000, 2'd0, 2'd0, 32'h7F800000};
    vecs[15] = '{1'b0, 9'd254, 48'h400000400001, 2'd0, 2'd0, 32'h3F800001};
    vecs[16] = '{1'b1, 9'd254, 48'h400000000000, 2'd3, 2'd2, 32'h7FC00000};
    vecs[17] = '{1'b0, 9'd254, 48'h400000000000, 2'd2, 2'd2, 32'h7F800000};
    vecs[18] = '{1'b1, 9'd255, 48'h600000000000, 2'd0, 2'd0, 32'hC0400000};
    bp_e[0] = 9'd254; bp_r[0] = 32'h3F800000;
    bp_e[1] = 9'd255; bp_r[1] = 32'h40000000;
    bp_e[2] = 9'd256; bp_r[2] = 32'h40800000;
    bp_e[3] = 9'd257; bp_r[3] = 32'h41000000;
    rstn = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drive(vecs[0]);
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_result", out_result, 32'h0);
    rstn = 1'b0;
    for (int i = 0; i < NV; i++) run_one($sformatf("vec%0d", i), vecs[i]);
    @(posedge clk);
    #1;
    sent = 0;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      in_valid = sent < 4;
      drive('{1'b0, bp_e[sent % 4], 48'h400000000000, 2'd0, 2'd0, 32'h0});
      out_ready = c >= 5;
      if (c == 2) begin
        check("bp in_ready drop", 32'(in_ready), 32'd0);
        check("bp beats held", 32'(sent), 32'd2);
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      ovs = out_valid;
      orr = out_ready;
      res = out_result;
      if (ovs && orr) begin
        check($sformatf("bp result%0d", got), res, bp_r[got]);
        got++;
      end
      @(posedge clk);
      #1;
      if (acc) sent++;
      if (ovs && !orr) begin
        check("bp stall valid", 32'(out_valid), 32'd1);
        check("bp stall stable", out_result, res);
      end
    end
    in_valid = 1'b0;
    check("bp count", 32'(got), 32'd4);
    repeat (3) @(posedge clk);
    #1;
    check("bp no duplicate", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    drive(vecs[3]);
    in_valid = 1'b1;
    @(posedge clk);
    #1 drive(vecs[7]);
    @(posedge clk);
    #1;
    check("full in_ready", 32'(in_ready), 32'd0);
    check("full out_valid", 32'(out_valid), 32'd1);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst in_ready", 32'(in_ready), 32'd1);
    check("midrst out_result", out_result, 32'h0);
    rstn = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("midrst drained", 32'(out_valid), 32'd0);
    run_one("after reset", vecs[0]);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
